mips_mem_arbiter: RTL

- Shares the single-port unified (von Neumann) memory between two requesters: port 0 is the multicycle CPU, port 1 is the debug/program-loader master.
- Decides which requester drives mem_addr/mem_wr_data/mem_wr_ena in each cycle, and returns read data with the memory's fixed one-cycle read latency.
- Sits between the CPU core's memory port and the memory block.

---
 rtl/mips_mem_arbiter_pkg.sv | 18 +
 rtl/mips_rr_arb2.sv | 47 ++++
 rtl/mips_mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// mips_mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter:
//   PORT_CPU / PORT_DBG : requester indices (port 0 = multicycle CPU,
//                         port 1 = debug/program-loader master)
//   ALIGN_MASK          : low address bits that must be zero for a word access
//   is_misaligned()     : applies ALIGN_MASK to the two low address bits
package mips_mem_arbiter_pkg;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mips_rr_arb2.sv
// mips_rr_arb2
// Two-requester picker. Holds the last_winner register and produces a one-hot
// (or zero) grant every cycle.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   i_req[1:0] : request vector, bit index = port number
//   o_gnt[1:0] : one-hot grant, combinational from i_req and last_winner
// FIXED_PRIO = 1 makes port 0 win every tie; 0 alternates on ties.
module mips_rr_arb2
    import mips_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Reset to the debug port so the CPU wins the first tie.
    logic r_last_winner;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11: begin
                if (FIXED_PRIO != 0)
                    o_gnt = 2'b01;
                else
                    o_gnt = r_last_winner ? 2'b01 : 2'b10;
            end
            default: o_gnt = 2'b00;
        endcase
    end

    // Any grant updates last_winner, including grants that end in a
    // misalignment error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_winner <= 1'b1;
        else if (|o_gnt)
            r_last_winner <= o_gnt[PORT_DBG];
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares the single-port unified memory between the CPU (port 0) and the
// debug/program-loader master (port 1). One access is issued per cycle; a
// granted read returns on rdata one cycle later, qualified by rvalid0/1.
//   clk, rst                  : clock, asynchronous active-low reset
//   reqX, weX, addrX, wdataX  : request, write enable, byte address, write data
//   gntX                      : access presented to memory this cycle
//   errX                      : granted access was misaligned and dropped
//   rvalidX, rdata            : read return for port X (shared data bus)
//   mem_addr/wr_data/wr_ena   : memory request side
//   mem_rd_data               : memory read data, one cycle after the address
//   gnt_cntX                  : saturating count of successful grants
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int N          = 32,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [N-1:0]     addr0,
    input  logic [N-1:0]     addr1,
    input  logic [N-1:0]     wdata0,
    input  logic [N-1:0]     wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             err0,
    output logic             err1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [N-1:0]     rdata,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_wr_data,
    output logic             mem_wr_ena,
    input  logic [N-1:0]     mem_rd_data,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic [1:0]   w_req;
    logic [1:0]   w_gnt;
    logic         w_win;
    logic         w_any;
    logic [N-1:0] w_addr;
    logic [N-1:0] w_wdata;
    logic         w_we;
    logic         w_mis;
    logic         w_ok;

    logic             r_pend_valid;
    logic             r_pend_port;
    logic [CNT_W-1:0] r_cnt [2];

    // Requests are masked while reset is held so every output reads 0.
    assign w_req = {req1, req0} & {2{rst}};

    mips_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign w_any   = |w_gnt;
    assign w_win   = w_gnt[PORT_DBG];
    assign w_addr  = w_win ? addr1  : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;
    assign w_we    = w_win ? we1    : we0;
    assign w_mis   = w_any && is_misaligned(w_addr[1:0]);
    assign w_ok    = w_any && !w_mis;

    assign gnt0 = w_gnt[PORT_CPU];
    assign gnt1 = w_gnt[PORT_DBG];
    assign err0 = w_gnt[PORT_CPU] && w_mis;
    assign err1 = w_gnt[PORT_DBG] && w_mis;

    // A dropped (misaligned) access never reaches the memory.
    assign mem_addr    = w_ok ? w_addr  : '0;
    assign mem_wr_data = w_ok ? w_wdata : '0;
    assign mem_wr_ena  = w_ok && w_we;

    // Only a successful read is tracked; the next grant proceeds in parallel
    // with the return of this one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_valid <= 1'b0;
            r_pend_port  <= 1'b0;
        end else begin
            r_pend_valid <= w_ok && !w_we;
            r_pend_port  <= w_win;
        end
    end

    assign rvalid0 = r_pend_valid && (r_pend_port == 1'b0);
    assign rvalid1 = r_pend_valid && (r_pend_port == 1'b1);
    assign rdata   = r_pend_valid ? mem_rd_data : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_cnt[gi] <= '0;
                else if (w_ok && w_gnt[gi] && (r_cnt[gi] != {CNT_W{1'b1}}))
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    endgenerate

    assign gnt_cnt0 = r_cnt[PORT_CPU];
    assign gnt_cnt1 = r_cnt[PORT_DBG];

endmodule
